// File: rtl/tm1638_display_arbiter.sv
// Round-robin arbiter feeding requester frames into a single TM1638 driver.
// One frame slot per requester; a newer frame replaces an unsent one.
module tm1638_display_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                            i_Clk,
   input  logic                            i_Rst,
   input  logic [NUM_REQ-1:0]              i_Req_Valid,
   input  logic [NUM_REQ-1:0][63:0]        i_Req_Segments,
   input  logic [NUM_REQ-1:0][7:0]         i_Req_Leds,
   output logic [NUM_REQ-1:0]              o_Req_Ack,
   input  logic                            i_Busy,
   output logic [63:0]                     o_Segments,
   output logic [7:0]                      o_Leds,
   output logic                            o_Valid,
   output logic [$clog2(NUM_REQ)-1:0]      o_Grant_Id,
   output logic                            o_Timeout
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [NUM_REQ-1:0][63:0] seg_q, seg_d;
   logic [NUM_REQ-1:0][7:0]  led_q, led_d;
   logic [NUM_REQ-1:0]       pend_q, pend_d;
   logic [NUM_REQ-1:0]       ack_q;
   logic [GW-1:0]            last_q, last_d;
   logic [GW-1:0]            gid_q, gid_d;
   logic [63:0]              oseg_q, oseg_d;
   logic [7:0]               oled_q, oled_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     to_q, to_d;

   logic                     pick_hit;
   logic [GW-1:0]            pick;
   int                       idx;

   // Scan downward so the requester closest after last grant wins.
   always_comb begin
      pick_hit = 1'b0;
      pick     = '0;
      idx      = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last_q) + k) % NUM_REQ;
         if (pend_q[idx]) begin
            pick_hit = 1'b1;
            pick     = GW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      seg_d   = seg_q;
      led_d   = led_q;
      pend_d  = pend_q;
      last_d  = last_q;
      gid_d   = gid_q;
      oseg_d  = oseg_q;
      oled_d  = oled_q;
      cnt_d   = cnt_q;
      to_d    = to_q;

      unique case (state_q)
         IDLE: begin
            if (pick_hit) begin
               oseg_d       = seg_q[pick];
               oled_d       = led_q[pick];
               gid_d        = pick;
               last_d       = pick;
               pend_d[pick] = 1'b0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT_BUSY;
            cnt_d   = '0;
         end
         WAIT_BUSY: begin
            if (i_Busy) begin
               state_d = WAIT_DONE;
               cnt_d   = '0;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               to_d    = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!i_Busy) begin
               state_d = IDLE;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               to_d    = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase

      // Capture after grant: a same-edge capture re-arms the slot.
      for (int i = 0; i < NUM_REQ; i++) begin
         if (i_Req_Valid[i]) begin
            seg_d[i]  = i_Req_Segments[i];
            led_d[i]  = i_Req_Leds[i];
            pend_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q <= IDLE;
         seg_q   <= '0;
         led_q   <= '0;
         pend_q  <= '0;
         ack_q   <= '0;
         last_q  <= GW'(NUM_REQ - 1);
         gid_q   <= '0;
         oseg_q  <= '0;
         oled_q  <= '0;
         cnt_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         seg_q   <= seg_d;
         led_q   <= led_d;
         pend_q  <= pend_d;
         ack_q   <= i_Req_Valid;
         last_q  <= last_d;
         gid_q   <= gid_d;
         oseg_q  <= oseg_d;
         oled_q  <= oled_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
      end
   end

   assign o_Req_Ack  = ack_q;
   assign o_Segments = oseg_q;
   assign o_Leds     = oled_q;
   assign o_Valid    = (state_q == ISSUE);
   assign o_Grant_Id = gid_q;
   assign o_Timeout  = to_q;

endmodule

// File: doc/tm1638_display_arbiter.md
TM1638_DISPLAY_ARBITER -- requirements
Module: tm1638_display_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of display requesters (legal range 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum cycles spent waiting on the driver per phase.
REQ-003 SHALL have port i_Clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_Rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_Req_Valid  in  NUM_REQ  per-requester 1-cycle frame-update pulse.
REQ-006 SHALL have port i_Req_Segments  in  NUM_REQ x segments_t (64)  per-requester segment frame, [grid][segment].
REQ-007 SHALL have port i_Req_Leds  in  NUM_REQ x leds_t (8)  per-requester LED frame.
REQ-008 SHALL have port o_Req_Ack  out  NUM_REQ  1-cycle pulse confirming capture of a requester frame.
REQ-009 SHALL have port i_Busy  in  1  TM1638 driver busy; high while a frame transfer is in progress.
REQ-010 SHALL have port o_Segments  out  segments_t (64)  frame to driver.
REQ-011 SHALL have port o_Leds  out  leds_t (8)  LEDs to driver.
REQ-012 SHALL have port o_Valid  out  1  1-cycle pulse; the driver starts a transfer of o_Segments/o_Leds.
REQ-013 SHALL have port o_Grant_Id  out  $clog2(NUM_REQ)  index of the requester whose frame is on o_Segments/o_Leds.
REQ-014 SHALL have port o_Timeout  out  1  sticky flag; set when a driver phase exceeds TIMEOUT_CYCLES.

Function
REQ-015 SHALL hold one frame slot (segments, leds, pending bit) per requester.
REQ-016 SHALL, on an edge where i_Req_Valid[i]=1, load slot i with the inputs, set pending[i], and assert o_Req_Ack[i] for the next cycle only.
REQ-017 SHALL make a new pulse on an already-pending slot overwrite its data (newest wins), still acked, with no duplicate transfer.
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-019 SHALL, in IDLE with any pending bit set, grant round-robin starting at (last grant + 1) mod NUM_REQ, copy that slot to o_Segments/o_Leds/o_Grant_Id, clear its pending bit, and go to ISSUE.
REQ-020 SHALL, when a capture and a grant hit the same slot on the same edge, keep pending set with the new data and send the old data now.
REQ-021 SHALL, in ISSUE, drive o_Valid=1 for exactly that cycle and go to WAIT_BUSY; o_Valid SHALL be 0 in every other state.
REQ-022 SHALL, in WAIT_BUSY, go to WAIT_DONE when i_Busy=1.
REQ-023 SHALL, in WAIT_DONE, go to IDLE when i_Busy=0.
REQ-024 SHALL count cycles in WAIT_BUSY and WAIT_DONE, clearing the count on each state entry; at TIMEOUT_CYCLES it SHALL set o_Timeout and go to IDLE.
REQ-025 SHALL clear o_Timeout only by reset.
REQ-026 SHALL hold o_Segments/o_Leds/o_Grant_Id stable from grant until the next grant.
REQ-027 SHALL give a latency of 2 cycles from i_Req_Valid (edge N capture, edge N+1 grant) to o_Valid high in cycle N+2, with the FSM idle and no contention.
REQ-028 SHALL keep capturing requests in all states; arbitration occurs only in IDLE.

Reset
REQ-029 SHALL, on i_Rst, immediately clear all slots, pending bits, o_Req_Ack, o_Valid, o_Segments=64'h0, o_Leds=8'h0, o_Grant_Id=0, o_Timeout=0, the counter, and set last grant=NUM_REQ-1 and state=IDLE.
REQ-030 SHALL, on reset mid-transfer, drop all pending frames and issue no o_Valid until a new request arrives after reset release.

Verification
REQ-031 Single request: pulse req0 with segments 64'h0123456789ABCDEF, leds 8'hA5 -> ack0 next cycle, o_Valid 2 cycles after the pulse, o_Grant_Id=0; driver busy 10 cycles -> back to IDLE.
REQ-032 Contention: req1, req2, req3 pulse on the same cycle after reset -> grants in order 1, 2, 3, one o_Valid per full busy cycle.
REQ-033 Overwrite: req2 pulses 8'h11 then 8'h22 while the FSM is in WAIT_DONE for req0 -> exactly one transfer for req2, with leds 8'h22.
REQ-034 Timeout: TIMEOUT_CYCLES=16, i_Busy held 0 after o_Valid -> o_Timeout=1 at cycle 16 of WAIT_BUSY, FSM in IDLE, next pending request served.
REQ-035 Async reset: assert i_Rst in WAIT_DONE with req1 pending -> all outputs reset without waiting for a clock edge, no o_Valid after release.
REQ-036 Fairness: all NUM_REQ requesters re-pulse continuously -> each is granted once per NUM_REQ transfers.
